mont_mul_w: RTL

MONT_MUL_W -- requirements
Module: mont_mul_w

---
 rtl/mont_pkg.sv | 17 +
 rtl/mont_step.sv | 23 ++
 rtl/mont_mul_w.sv | 117 +++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// Shared types and constants for the bit-serial Montgomery multiplier.
package mont_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2
  } state_t;

  // Counter must be able to represent WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: S' = (S + a_i*B + q*N) / 2, q chosen to make the sum even.
module mont_step
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH+1:0] s,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH+1:0] s_next_c
);

  localparam int unsigned SW = WIDTH + 2;

  logic [SW-1:0] sum_ab_c;

  assign sum_ab_c = s + (a_bit ? {2'b00, b} : '0);

  // One guard bit on the final add so the halving never loses a carry.
  assign s_next_c = SW'(({1'b0, sum_ab_c} + (sum_ab_c[0] ? {3'b000, n} : '0)) >> 1);

endmodule

// File: rtl/mont_mul_w.sv
// Bit-serial Montgomery multiplier: Z = A*B*2^-WIDTH mod N in WIDTH+1 cycles after start.
// Define MONT_OPERAND_CHECK_EN to reject even N or A/B >= N with err.
module mont_mul_w
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] Z,
  output logic             busy,
  output logic             module_end,
  output logic             err
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned SW    = WIDTH + 2;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] n_q;
  logic [SW-1:0]    s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SW-1:0]    s_next_c;
  logic [SW-1:0]    n_ext_c;
  logic [WIDTH-1:0] z_final_c;

  mont_step #(.WIDTH(WIDTH)) u_step (
    .s        (s_q),
    .a_bit    (a_q[0]),
    .b        (b_q),
    .n        (n_q),
    .s_next_c (s_next_c)
  );

  // Final conditional subtraction brings S from [0, 2N) into [0, N).
  assign n_ext_c   = {2'b00, n_q};
  assign z_final_c = WIDTH'((s_q >= n_ext_c) ? (s_q - n_ext_c) : s_q);

`ifdef MONT_OPERAND_CHECK_EN
  logic op_bad_c;
  logic bad_q;
  logic err_q;

  assign op_bad_c = ~N[0] | (A >= N) | (B >= N);
  assign err      = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      n_q        <= '0;
      s_q        <= '0;
      cnt_q      <= '0;
      Z          <= '0;
      busy       <= 1'b0;
      module_end <= 1'b0;
`ifdef MONT_OPERAND_CHECK_EN
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      module_end <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            n_q   <= N;
            s_q   <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
            state <= CALC;
`ifdef MONT_OPERAND_CHECK_EN
            err_q <= 1'b0;
            bad_q <= op_bad_c;
            if (op_bad_c) state <= FINAL;
`endif
          end
        end
        // A is consumed LSB first by shifting the latched copy.
        CALC: begin
          s_q   <= s_next_c;
          a_q   <= a_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state <= FINAL;
        end
        FINAL: begin
          busy       <= 1'b0;
          module_end <= 1'b1;
          state      <= IDLE;
`ifdef MONT_OPERAND_CHECK_EN
          if (bad_q) begin
            Z     <= '0;
            err_q <= 1'b1;
          end else begin
            Z <= z_final_c;
          end
`else
          Z <= z_final_c;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
